// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and constants for the ARM pipeline execute stage
//
// Contents:
//   NFLAGS          width of the architectural flag vector {N,Z,C,V}
//   FLAG_N..FLAG_V  bit positions inside the flag vector
//   cond_t          4-bit ARM condition field encodings
//   ectrl_t         control fields held in the E pipeline register

package arm_pkg;

    localparam int NFLAGS = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    typedef struct packed {
        cond_t      cond;
        logic [1:0] flag_w;
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] alu_control;
    } ectrl_t;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-code evaluator
//
// Ports:
//   cond   in  cond_t        condition field of the instruction
//   nzcv   in  [NFLAGS-1:0]  flag vector {N,Z,C,V}
//   pass   out 1             condition satisfied

module cond_check
    import arm_pkg::*;
(
    input  cond_t              cond,
    input  logic [NFLAGS-1:0]  nzcv,
    output logic               pass
);

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;
    logic ge_f;

    always_comb begin
        n_f  = nzcv[FLAG_N];
        z_f  = nzcv[FLAG_Z];
        c_f  = nzcv[FLAG_C];
        v_f  = nzcv[FLAG_V];
        ge_f = (n_f == v_f);
    end

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_f;
            COND_NE: pass = ~z_f;
            COND_CS: pass = c_f;
            COND_CC: pass = ~c_f;
            COND_MI: pass = n_f;
            COND_PL: pass = ~n_f;
            COND_VS: pass = v_f;
            COND_VC: pass = ~v_f;
            COND_HI: pass = c_f & ~z_f;
            COND_LS: pass = ~c_f | z_f;
            COND_GE: pass = ge_f;
            COND_LT: pass = ~ge_f;
            COND_GT: pass = ~z_f & ge_f;
            COND_LE: pass = z_f | ~ge_f;
            COND_AL: pass = 1'b1;
            // NV never executes.
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// rtl/cond_exec_stage.sv - E-stage control register, condition gating and NZCV register
//
// Ports:
//   clk          in  1  rising-edge clock
//   reset        in  1  asynchronous active-low reset
//   CondD        in  4  condition field of the instruction in D
//   FlagWD       in  2  flag write enables, [1] N,Z  [0] C,V
//   PCSD, RegWD, MemWD, MemtoRegD, ALUSrcAD, ALUSrcBD  in 1 each  decoder controls
//   ALUControlD  in  3  ALU operation
//   StallE       in  1  hold the E register
//   FlushE       in  1  load a bubble into E (wins over StallE)
//   ALUFlags     in  4  {N,Z,C,V} from the ALU for the instruction in E
//   ALUControlE  out 3  registered ALU operation
//   ALUSrcAE, ALUSrcBE, MemtoRegE  out 1 each  registered controls
//   CondExE      out 1  condition passed for the instruction in E
//   PCSrcE, RegWriteE, MemWriteE   out 1 each  condition/stall gated controls
//   Flags        out 4  architectural {N,Z,C,V}

module cond_exec_stage
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        CondD,
    input  logic [1:0]        FlagWD,
    input  logic              PCSD,
    input  logic              RegWD,
    input  logic              MemWD,
    input  logic              MemtoRegD,
    input  logic              ALUSrcAD,
    input  logic              ALUSrcBD,
    input  logic [2:0]        ALUControlD,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic [NFLAGS-1:0] ALUFlags,
    output logic [2:0]        ALUControlE,
    output logic              ALUSrcAE,
    output logic              ALUSrcBE,
    output logic              MemtoRegE,
    output logic              CondExE,
    output logic              PCSrcE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic [NFLAGS-1:0] Flags
);

    ectrl_t            ctrl_in;
    ectrl_t            e_d;
    ectrl_t            e_q;
    logic [NFLAGS-1:0] flags_d;
    logic [NFLAGS-1:0] flags_q;
    logic              cond_pass;
    logic              go;

    always_comb begin
        ctrl_in             = '0;
        ctrl_in.cond        = cond_t'(CondD);
        ctrl_in.flag_w      = FlagWD;
        ctrl_in.pcs         = PCSD;
        ctrl_in.reg_w       = RegWD;
        ctrl_in.mem_w       = MemWD;
        ctrl_in.mem_to_reg  = MemtoRegD;
        ctrl_in.alu_src_a   = ALUSrcAD;
        ctrl_in.alu_src_b   = ALUSrcBD;
        ctrl_in.alu_control = ALUControlD;
    end

    // A bubble is all-zero: Cond=EQ may pass, but every write control is 0.
    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = '0;
        end else if (!StallE) begin
            e_d = ctrl_in;
        end
    end

    cond_check u_cond_check (
        .cond (e_q.cond),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    // While stalled the same instruction is re-presented next cycle, so its
    // side effects are held off until the cycle it actually leaves E.
    always_comb begin
        go = cond_pass & ~StallE;
    end

    // N,Z and C,V are independent write groups; unwritten flags hold.
    always_comb begin
        flags_d = flags_q;
        if (go) begin
            if (e_q.flag_w[1]) begin
                flags_d[FLAG_N] = ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (e_q.flag_w[0]) begin
                flags_d[FLAG_C] = ALUFlags[FLAG_C];
                flags_d[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q     <= '0;
            flags_q <= '0;
        end else begin
            e_q     <= e_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        ALUControlE = e_q.alu_control;
        ALUSrcAE    = e_q.alu_src_a;
        ALUSrcBE    = e_q.alu_src_b;
        MemtoRegE   = e_q.mem_to_reg;
        CondExE     = cond_pass;
        PCSrcE      = e_q.pcs & go;
        RegWriteE   = e_q.reg_w & go;
        MemWriteE   = e_q.mem_w & go;
        Flags       = flags_q;
    end

endmodule

// File: tb/tb_cond_exec_stage.sv
// tb/tb_cond_exec_stage.sv - self-checking bench for cond_exec_stage

module tb_cond_exec_stage;
    import arm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] CondD;
    logic [1:0] FlagWD;
    logic       PCSD, RegWD, MemWD, MemtoRegD, ALUSrcAD, ALUSrcBD;
    logic [2:0] ALUControlD;
    logic       StallE, FlushE;
    logic [3:0] ALUFlags;
    logic [2:0] ALUControlE;
    logic       ALUSrcAE, ALUSrcBE, MemtoRegE, CondExE, PCSrcE, RegWriteE, MemWriteE;
    logic [3:0] Flags;

    always #5 clk = ~clk;

    cond_exec_stage dut (
        .clk         (clk),
        .reset       (reset),
        .CondD       (CondD),
        .FlagWD      (FlagWD),
        .PCSD        (PCSD),
        .RegWD       (RegWD),
        .MemWD       (MemWD),
        .MemtoRegD   (MemtoRegD),
        .ALUSrcAD    (ALUSrcAD),
        .ALUSrcBD    (ALUSrcBD),
        .ALUControlD (ALUControlD),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .ALUFlags    (ALUFlags),
        .ALUControlE (ALUControlE),
        .ALUSrcAE    (ALUSrcAE),
        .ALUSrcBE    (ALUSrcBE),
        .MemtoRegE   (MemtoRegE),
        .CondExE     (CondExE),
        .PCSrcE      (PCSrcE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .Flags       (Flags)
    );

    // {ALUControlE, ALUSrcAE, ALUSrcBE, MemtoRegE, CondExE, PCSrcE, RegWriteE, MemWriteE}
    logic [9:0] outs;
    assign outs = {ALUControlE, ALUSrcAE, ALUSrcBE, MemtoRegE, CondExE, PCSrcE, RegWriteE, MemWriteE};

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] cond;
        logic [3:0] nzcv;
        logic       pass;
    } vec_t;

    vec_t vecs[256];
    vec_t sb[$];

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic pcs,
                         input logic rw, input logic mw, input logic mtr,
                         input logic sa, input logic sb_i, input logic [2:0] alu);
        CondD       = c;
        FlagWD      = fw;
        PCSD        = pcs;
        RegWD       = rw;
        MemWD       = mw;
        MemtoRegD   = mtr;
        ALUSrcAD    = sa;
        ALUSrcBD    = sb_i;
        ALUControlD = alu;
    endtask

    task automatic nop();
        drive(4'hE, 2'b00, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic setter();
        drive(4'hE, 2'b11, 0, 0, 0, 0, 0, 0, 3'b010);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            vecs[i].cond = i[7:4];
            vecs[i].nzcv = i[3:0];
            vecs[i].pass = ref_cond(i[7:4], i[3:0]);
        end

        // Reset holds everything at 0 even with active D inputs and edges.
        reset = 1'b0; StallE = 0; FlushE = 0; ALUFlags = 4'b1111;
        drive(4'hE, 2'b11, 1, 1, 1, 1, 1, 1, 3'b111);
        #12;
        chk("reset_outs", outs, 10'b0);
        chk("reset_flags", {6'b0, Flags}, 10'b0);
        #1 reset = 1'b1;
        ALUFlags = 4'b0000;

        // Flush with live D controls yields a bubble.
        drive(4'hE, 2'b00, 0, 1, 0, 0, 0, 0, 3'b001);
        FlushE = 1;
        tick();
        FlushE = 0;
        #1 chk("flush_bubble", outs, 10'b0);

        // Flush and stall together still yield a bubble.
        drive(4'hE, 2'b00, 0, 1, 0, 0, 1, 0, 3'b101);
        tick();
        #1 chk("preload", outs, 10'b101_1_0_0_1_0_1_0);
        FlushE = 1; StallE = 1;
        #1 chk("stall_gates_regw", outs, 10'b101_1_0_0_1_0_0_0);
        tick();
        FlushE = 0; StallE = 0;
        nop();
        #1 chk("flush_stall_bubble", outs, 10'b0);

        // AL STR stalled two cycles: MemWriteE 0, 0, then 1 for one cycle.
        drive(4'hE, 2'b00, 0, 0, 1, 0, 0, 1, 3'b000);
        tick();
        StallE = 1;
        drive(4'hE, 2'b00, 0, 1, 0, 0, 0, 0, 3'b011);
        #1 chk("stall_c1_memw", {9'b0, MemWriteE}, 10'd0);
        tick();
        #1 chk("stall_c2_memw", {9'b0, MemWriteE}, 10'd0);
        tick();
        StallE = 0;
        nop();
        #1 chk("release_memw", outs, 10'b000_0_1_0_1_0_0_1);
        tick();
        #1 chk("after_release_memw", {9'b0, MemWriteE}, 10'd0);

        // CMP then BEQ / BNE.
        setter();
        tick();
        ALUFlags = 4'b0100;
        drive(4'h0, 2'b00, 1, 0, 0, 0, 0, 0, 3'b000);
        tick();
        ALUFlags = 4'b0000;
        drive(4'h1, 2'b00, 1, 0, 0, 0, 0, 0, 3'b000);
        #1 chk("cmp_flags", {6'b0, Flags}, 10'b0100);
        chk("beq_taken", {9'b0, PCSrcE}, 10'd1);
        tick();
        nop();
        #1 chk("bne_not_taken", {9'b0, PCSrcE}, 10'd0);
        chk("bne_flags_hold", {6'b0, Flags}, 10'b0100);

        // Partial flag write: only N,Z change.
        setter();
        tick();
        ALUFlags = 4'b0110;
        drive(4'hE, 2'b10, 0, 0, 0, 0, 0, 0, 3'b000);
        tick();
        ALUFlags = 4'b1001;
        nop();
        #1 chk("partial_pre", {6'b0, Flags}, 10'b0110);
        tick();
        #1 chk("partial_nz", {6'b0, Flags}, 10'b1010);

        // Failed condition suppresses every side effect.
        setter();
        tick();
        ALUFlags = 4'b0100;
        drive(4'h1, 2'b11, 0, 1, 1, 0, 0, 0, 3'b000);
        tick();
        ALUFlags = 4'bxxxx;
        nop();
        #1 chk("fail_cond", {7'b0, CondExE, RegWriteE, MemWriteE}, 10'b000);
        chk("fail_flags_pre", {6'b0, Flags}, 10'b0100);
        tick();
        ALUFlags = 4'b0000;
        #1 chk("fail_flags_kept", {6'b0, Flags}, 10'b0100);

        // Asynchronous reset mid-stream with RegW pending.
        setter();
        tick();
        ALUFlags = 4'b1111;
        drive(4'hE, 2'b00, 0, 1, 0, 0, 0, 0, 3'b000);
        tick();
        ALUFlags = 4'b0000;
        nop();
        chk("pending_regw", {9'b0, RegWriteE}, 10'd1);
        chk("pending_flags", {6'b0, Flags}, 10'b1111);
        #2 reset = 1'b0;
        #1 chk("async_reset_outs", outs, 10'b0);
        chk("async_reset_flags", {6'b0, Flags}, 10'b0);
        #2 reset = 1'b1;
        tick();

        // Sweep all conditions against all flag values through a scoreboard.
        for (int i = 0; i < 256; i++) begin
            vec_t e;
            setter();
            tick();
            ALUFlags = vecs[i].nzcv;
            drive(vecs[i].cond, 2'b00, 1, 0, 0, 0, 0, 0, 3'b000);
            sb.push_back(vecs[i]);
            tick();
            ALUFlags = 4'($urandom_range(0, 15));
            if (sb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL sweep_sb_empty at %0d", i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("sweep_flags c=%h", e.cond), {6'b0, Flags}, {6'b0, e.nzcv});
                chk($sformatf("sweep_pcsrc c=%h f=%b", e.cond, e.nzcv), {9'b0, PCSrcE}, {9'b0, e.pass});
                chk($sformatf("sweep_condex c=%h f=%b", e.cond, e.nzcv), {9'b0, CondExE}, {9'b0, e.pass});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_exec_stage.md
# cond_exec_stage

Execute-stage control register and conditional-execution unit for the pipelined ARM core. Each cycle it captures the decode-stage control bundle (`RegW`, `MemW`, `PCS`, `FlagW`, `ALUControl` and related signals, plus the instruction condition field) into the E stage. It evaluates the 4-bit ARM condition against the architectural NZCV flag register and gates the write and branch controls on the result. It also owns the NZCV register, which it updates from the ALU flags produced in E.

## Interface
Parameters:
- `NFLAGS`, 4: width of the flag vector, ordered {N,Z,C,V}; fixed at 4 and not overridable.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `CondD`  in  4  Instr[31:28] of the instruction in D.
- `FlagWD`  in  2  flag-write enables from the decoder. [1] writes N,Z; [0] writes C,V.
- `PCSD`, `RegWD`, `MemWD`, `MemtoRegD`, `ALUSrcAD`, `ALUSrcBD`  in  1 each  decoder controls.
- `ALUControlD`  in  3  ALU operation.
- `StallE`  in  1  hold the E register.
- `FlushE`  in  1  insert a bubble into E.
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU for the instruction in E.
- `ALUControlE`  out  3  registered ALU operation.
- `ALUSrcAE`, `ALUSrcBE`, `MemtoRegE`  out  1 each  registered controls.
- `CondExE`  out  1  condition passed for the instruction in E.
- `PCSrcE`, `RegWriteE`, `MemWriteE`  out  1 each  gated controls.
- `Flags`  out  4  architectural NZCV, {N,Z,C,V}.

## Operation
- E register fields: Cond, FlagW, PCS, RegW, MemW, MemtoReg, ALUSrcA, ALUSrcB, ALUControl.
- Register priority on each edge:
  - `FlushE` = 1: all E fields load 0. This is a bubble; Cond = 0000 is harmless because every write control is 0.
  - else `StallE` = 1: all E fields hold.
  - else: all E fields load their D inputs.
  - `FlushE` wins over `StallE`.
- Condition evaluation (combinational, on E Cond and `Flags`):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) 1. Code 1111 is unimplemented and evaluates to 0.
- Gating, with `go = CondExE & !StallE`:
  - `PCSrcE = PCS & go`, `RegWriteE = RegW & go`, `MemWriteE = MemW & go`.
- Flag update on the edge, only when `go` = 1:
  - FlagW[1] loads N,Z from `ALUFlags[3:2]`.
  - FlagW[0] loads C,V from `ALUFlags[1:0]`.
  - The two groups update independently. A flag not written holds its value.
- A failed condition suppresses all side effects: no register write, no memory write, no branch, no flag update.
- Reset (asynchronous, mid-operation allowed): all E fields, `Flags`, and therefore every output go to 0 immediately. Normal operation resumes on the first edge after deassertion.

## Timing
- Latency: D controls appear on the E outputs one cycle after the capturing edge.
- `CondExE` and the gated outputs are combinational from the E register and `Flags`; there is no extra cycle.
- Flag producer followed by consumer (e.g. CMP then BEQ in consecutive cycles):
  - The new flags are written on the edge at which the producer leaves E.
  - The consumer evaluates against the updated flags in the next cycle. No forwarding is needed.
- While `StallE` = 1:
  - The gated outputs read 0 every cycle, so downstream captures bubbles.
  - They assert for exactly one cycle after release, if the condition passes.
- `ALUFlags` is sampled only on the update edge and may be X when `go` = 0.

## Structure
- The shared package `arm_pkg` holds:
  - the `cond_t` enum (EQ..AL, NV);
  - named constants for the NZCV bit positions;
  - the `ectrl_t` packed struct bundling the E-register control fields.
- Sub-module: `cond_check` is the pure combinational condition evaluator (inputs `cond_t` and NZCV, output pass). It is reused by any future branch predictor check.
- The top level holds the E register, the flag register and the gating logic.

## Test plan
- Reset mid-stream with RegW=1 pending in E → `RegWriteE`=0, `Flags`=0000 asynchronously, before the next edge.
- Flag producer then branch:
  - CMP (Cond=1110, FlagWD=11) with `ALUFlags`=0100 → next cycle `Flags`=0100.
  - BEQ following it (Cond=0000, PCSD=1) → `PCSrcE`=1.
  - BNE in the same position → `PCSrcE`=0.
- Partial flag write: `Flags`=0110, FlagWD=10, `ALUFlags`=1001 → `Flags`=1010 (C,V retained).
- Failed condition: `Flags`=0100, Cond=0001 (NE), RegWD=MemWD=1, FlagWD=11 → `CondExE`=0, `RegWriteE`=`MemWriteE`=0, `Flags` still 0100.
- Flush and stall:
  - `FlushE` with RegWD=1, ALUControlD=001 → next cycle all E outputs 0.
  - `FlushE` and `StallE` together → bubble.
  - `StallE` held 2 cycles on an AL STR → `MemWriteE`=0 both cycles, then 1 for one cycle after release.
- Exhaustive sweep: all 16 Cond codes × all 16 NZCV values with `PCSD`=1 → `PCSrcE` matches the condition table. Code 1111 always gives 0.
